serial_frame_ctrl: RTL and testbench

- Parametrised successor to the fixed serial-receive controller.
- Detects a start bit on a serial line, shifts in a channel-id header and a length field, then routes exactly that many payload bits to one of 2**HDR_BITS channels.
- Header and length counters are internal, so no external counter load/enable handshake is needed.
- Adds bit-strobe stalling, a zero-length frame path, an abort input and a frame-done pulse.

---
 rtl/serial_frame_ctrl.sv | 135 +++++++++++++
 tb/tb_serial_frame_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/serial_frame_ctrl.sv
// Serial frame receiver: start bit, channel-id header, length field, then routes payload bits to one channel.
// Optional trailing even-parity bit check is enabled with `define PARITY_CHK_EN.
module serial_frame_ctrl #(
  parameter int HDR_BITS = 2,
  parameter int LEN_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ser_in,
  input  logic                     bit_en,
  input  logic                     abort,
  output logic                     dout,
  output logic [2**HDR_BITS-1:0]   dval,
  output logic [HDR_BITS-1:0]      ch_id,
  output logic                     busy,
  output logic                     done,
  output logic                     frame_err
);

  // state   | meaning
  // IDLE    | waiting for a start bit (ser_in=0 on a strobed cycle)
  // HDR     | shifting in the channel id, MSB first
  // LEN     | shifting in the payload length, MSB first
  // PAYLOAD | forwarding payload bits to dval[ch_id]
  // PAR     | consuming the parity bit (parity build only)
  // FIN     | one-cycle done pulse, then back to IDLE
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LEN, S_PAYLOAD, S_FIN, S_PAR
  } state_t;

  localparam int NCH  = 2**HDR_BITS;
  localparam int MAXB = (HDR_BITS > LEN_BITS) ? HDR_BITS : LEN_BITS;
  localparam int CW   = $clog2(MAXB + 1);

`ifdef PARITY_CHK_EN
  localparam state_t S_BODY_END = S_PAR;
`else
  localparam state_t S_BODY_END = S_FIN;
`endif

  state_t              state, state_n;
  logic [CW-1:0]       cnt;
  logic [LEN_BITS-1:0] len_reg;
  logic [LEN_BITS-1:0] remaining;
  logic [LEN_BITS-1:0] len_full;
  logic                take;
  logic                hdr_last;
  logic                len_last;

  assign dout     = ser_in;
  assign busy     = (state != S_IDLE);
  assign take     = bit_en && !abort && !rst;
  assign len_full = LEN_BITS'({len_reg, ser_in});
  assign hdr_last = (cnt == CW'(HDR_BITS - 1));
  assign len_last = (cnt == CW'(LEN_BITS - 1));

  always_comb begin
    state_n = state;
    dval    = '0;
    case (state)
      S_IDLE:    if (take && !ser_in) state_n = S_HDR;
      S_HDR:     if (take && hdr_last) state_n = S_LEN;
      S_LEN:
        if (take && len_last) state_n = (len_full == '0) ? S_BODY_END : S_PAYLOAD;
      S_PAYLOAD:
        if (take) begin
          dval = NCH'(1) << ch_id;
          if (remaining <= LEN_BITS'(1)) state_n = S_BODY_END;
        end
      S_PAR:     if (take) state_n = S_FIN;
      S_FIN:     state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ch_id     <= '0;
      len_reg   <= '0;
      remaining <= '0;
      cnt       <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_n;
      done  <= (state_n == S_FIN);
      if (!abort && bit_en) begin
        case (state)
          S_IDLE: if (!ser_in) cnt <= '0;
          S_HDR: begin
            ch_id <= HDR_BITS'({ch_id, ser_in});
            cnt   <= hdr_last ? '0 : cnt + CW'(1);
          end
          S_LEN: begin
            len_reg <= len_full;
            if (len_last) begin
              cnt       <= '0;
              remaining <= len_full;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_PAYLOAD: if (remaining != '0) remaining <= remaining - LEN_BITS'(1);
          default: ;
        endcase
      end
    end
  end

`ifdef PARITY_CHK_EN
  logic par_acc;

  // Accumulator covers header, length and payload bits; the start bit is excluded.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      par_acc   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (bit_en) begin
        case (state)
          S_IDLE:                   if (!ser_in) par_acc <= 1'b0;
          S_HDR, S_LEN, S_PAYLOAD:  par_acc <= par_acc ^ ser_in;
          S_PAR:                    frame_err <= par_acc ^ ser_in;
          default: ;
        endcase
      end
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Randomised bench for serial_frame_ctrl: frames are built as bit lists and outputs predicted per bit position.
module tb_serial_frame_ctrl;
  localparam int H   = 2;
  localparam int L   = 4;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ser_in = 1'b1;
  logic bit_en = 1'b0;
  logic abort = 1'b0;
  logic dout;
  logic [NCH-1:0] dval;
  logic [H-1:0] ch_id;
  logic busy, done, frame_err;

  int n_checks = 0;
  int n_fail = 0;

  serial_frame_ctrl #(.HDR_BITS(H), .LEN_BITS(L)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .bit_en(bit_en), .abort(abort),
    .dout(dout), .dval(dval), .ch_id(ch_id), .busy(busy), .done(done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic be, input logic si, input logic ab, input logic r);
    @(posedge clk);
    #1;
    bit_en = be;
    ser_in = si;
    abort  = ab;
    rst    = r;
    @(negedge clk);
  endtask

  // kill_mode: 0 none, 1 abort, 2 rst, 3 rst+abort (applied on bit index kill_at)
  task automatic send_frame(input int ch, input int len, input int pl, input int stall_max,
                            input bit stall_fixed, input bit flip, input int kill_at,
                            input int kill_mode);
    bit q[$];
    bit acc;
    bit exp_err;
    int first_pl;
    int ns;
    logic [NCH-1:0] exp_dval;
    first_pl = 1 + H + L;
    acc = 1'b0;
    exp_err = 1'b0;
    q.push_back(1'b0);
    for (int b = H - 1; b >= 0; b--) q.push_back(ch[b]);
    for (int b = L - 1; b >= 0; b--) q.push_back(len[b]);
    for (int k = 0; k < len; k++) q.push_back(pl[len - 1 - k]);
    for (int i = 1; i < q.size(); i++) acc ^= q[i];
`ifdef PARITY_CHK_EN
    q.push_back(acc ^ flip);
    exp_err = flip;
`endif
    for (int i = 0; i < q.size(); i++) begin
      ns = stall_fixed ? stall_max : int'($urandom_range(stall_max));
      for (int s = 0; s < ns; s++) begin
        step(1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
        chk("stall_dval", 32'(dval), 32'(0));
        chk("stall_busy", 32'(busy), 32'(i > 0));
        chk("stall_done", 32'(done), 32'(0));
      end
      if (i == kill_at) begin
        step(1'b1, q[i], 1'(kill_mode & 1), 1'((kill_mode >> 1) & 1));
        if ((kill_mode & 1) != 0) chk("abort_dval", 32'(dval), 32'(0));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("kill_busy", 32'(busy), 32'(0));
        chk("kill_done", 32'(done), 32'(0));
        chk("kill_err", 32'(frame_err), 32'(0));
        chk("kill_dval", 32'(dval), 32'(0));
        chk("kill_ch_id", 32'(ch_id), (kill_mode >= 2) ? 32'(0) : 32'(ch));
        return;
      end
      step(1'b1, q[i], 1'b0, 1'b0);
      exp_dval = (i >= first_pl && i < first_pl + len) ? NCH'(1) << ch : '0;
      chk("bit_dval", 32'(dval), 32'(exp_dval));
      if (exp_dval != '0) chk("bit_dout", 32'(dout), 32'(q[i]));
      chk("bit_busy", 32'(busy), 32'(i > 0));
      chk("bit_done", 32'(done), 32'(0));
    end
    step(1'($urandom_range(1)), 1'b1, 1'b0, 1'b0);
    chk("fin_done", 32'(done), 32'(1));
    chk("fin_err", 32'(frame_err), 32'(exp_err));
    chk("fin_ch_id", 32'(ch_id), 32'(ch));
    chk("fin_busy", 32'(busy), 32'(1));
    chk("fin_dval", 32'(dval), 32'(0));
  endtask

  initial begin
    int len, ka, km;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(frame_err), 32'(0));
    chk("rst_ch_id", 32'(ch_id), 32'(0));
    chk("rst_dval", 32'(dval), 32'(0));
    step(1'b0, 1'b1, 1'b0, 1'b0);

    send_frame(2, 3, 5, 0, 1'b0, 1'b0, -1, 0);
    send_frame(3, 0, 0, 0, 1'b0, 1'b0, -1, 0);
    send_frame(2, 3, 5, 1, 1'b1, 1'b0, -1, 0);
    send_frame(0, 15, 16'h5a3c, 0, 1'b0, 1'b0, -1, 0);
    send_frame(1, 2, 2, 0, 1'b0, 1'b0, -1, 0);
    send_frame(2, 3, 5, 0, 1'b0, 1'b0, 1 + H + L + 1, 1);
    send_frame(3, 5, 9, 0, 1'b0, 1'b0, 1 + H + 1, 2);
    send_frame(1, 4, 6, 0, 1'b0, 1'b0, 1 + H + 2, 3);
    send_frame(1, 2, 1, 0, 1'b0, 1'b0, -1, 0);
    send_frame(1, 2, 1, 0, 1'b0, 1'b1, -1, 0);

    for (int f = 0; f < 60; f++) begin
      len = int'($urandom_range(15));
      ka = -1;
      km = 0;
      if ($urandom_range(7) == 0) begin
        ka = int'($urandom_range(H + L + len, H + 1));
        km = int'($urandom_range(3, 1));
      end
      send_frame(int'($urandom_range(NCH - 1)), len, int'($urandom_range(16'hffff)),
                 int'($urandom_range(2)), 1'b0, 1'($urandom_range(1)), ka, km);
      if ($urandom_range(3) == 0) step(1'b1, 1'b1, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
